uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO.
// Frame: start bit, DATA_BITS payload bits (LSB first), optional parity bit,
// STOP_BITS stop bits. The bit period is CLKS_PER_BIT = round(CLK_FREQ/BAUD).
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN,
// which adds the send_break input and the BRK/BRK_GUARD states.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic                          send_break,
`endif
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int DW  = (CPB >= 2) ? $clog2(CPB) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CPB - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

`ifdef UART_TX_BREAK_EN
  localparam int FRAME_CLKS = (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS) * CPB;
  localparam int BRK_MIN    = 2 * FRAME_CLKS;
  localparam int BW         = $clog2(BRK_MIN + 1);
  localparam logic [BW-1:0] BRK_LAST = BW'(BRK_MIN - 1);
`endif

  // Reject parameter sets the datapath cannot represent.
  if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
`ifdef UART_TX_BREAK_EN
    ,
    S_BRK,
    S_BRK_GUARD
`endif
  } state_t;

  state_t               state_q;
  logic [DW-1:0]        div_q;
  logic [3:0]           bit_q;
  logic                 txd_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
`ifdef UART_TX_BREAK_EN
  logic [BW-1:0]        brk_q;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;

  logic                 push, pop, fifo_empty, bit_end, shift_en;
  logic [DATA_BITS-1:0] head;

  // Parity bit for a payload word: even parity is the plain XOR, odd its inverse.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~(^w) : (^w);
  endfunction

  assign tx_ready   = (count_q != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count_q == '0);
  assign bit_end    = (div_q == DIV_LAST);
  assign head       = mem_q[rd_ptr_q];
  assign shift_en   = (state_q == S_DATA) && bit_end && (bit_q != DATA_LAST);
  assign txd        = txd_q;
  assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = count_q;

  // Pop the FIFO head when a frame is about to start (from idle or straight after a stop).
  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        pop = !fifo_empty && !send_break;
`else
        pop = !fifo_empty;
`endif
      end
      S_STOP:  pop = bit_end && (bit_q == STOP_LAST) && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Next FIFO occupancy: push and pop on the same edge cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // Shift register and latched parity, loaded from the FIFO head on each pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= head;
      par_q   <= parity_of(head);
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Frame sequencer; txd is registered and always reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          div_q <= '0;
          bit_q <= '0;
          txd_q <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            state_q <= S_BRK;
            txd_q   <= 1'b0;
            brk_q   <= '0;
          end else
`endif
          if (!fifo_empty) begin
            state_q <= S_START;
            txd_q   <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            div_q <= '0;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PAR;
                txd_q   <= par_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
              txd_q <= shift_q[1];
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_PAR: begin
          if (bit_end) begin
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            div_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (!fifo_empty) begin
                state_q <= S_START;
                txd_q   <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BRK: begin
          txd_q <= 1'b0;
          if (brk_q == BRK_LAST && !send_break) begin
            state_q <= S_BRK_GUARD;
            txd_q   <= 1'b1;
            div_q   <= '0;
          end else if (brk_q != BRK_LAST) begin
            brk_q <= brk_q + BW'(1);
          end
        end
        S_BRK_GUARD: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            div_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter sets (8N1, 8E1, 8O1, 7N2) at 10
// clocks per bit share one stimulus stream. Each set has a timeline model
// that predicts txd, fifo_count, tx_ready and tx_busy every cycle from
// frame start times; directed literal checks pin the model to known values.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB   = 10;
  localparam int NCFG  = 4;
  localparam int DEPTH = 4;
  localparam logic [3:0][3:0] CFG_DB  = {4'd7, 4'd8, 4'd8, 4'd8};
  localparam logic [3:0][1:0] CFG_PAR = {2'd0, 2'd1, 2'd2, 2'd0};
  localparam logic [3:0][1:0] CFG_SB  = {2'd2, 2'd1, 2'd1, 2'd1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [8:0] tx_data = '0;
`ifdef UART_TX_BREAK_EN
  logic       send_break = 1'b0;
`endif

  logic       rdy_w  [NCFG];
  logic       txd_w  [NCFG];
  logic       busy_w [NCFG];
  logic [2:0] cnt_w  [NCFG];

  int         edge_no = 0;
  logic       v_edge = 1'b0;
  logic       r_edge = 1'b0;
  logic [8:0] d_edge = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Record what the DUT saw at each rising edge.
  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    v_edge  <= tx_valid;
    r_edge  <= rst_n;
    d_edge  <= tx_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
    localparam int DB  = int'(CFG_DB[g]);
    localparam int PAR = int'(CFG_PAR[g]);
    localparam int SB  = int'(CFG_SB[g]);
    localparam int F   = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CPB;

    uart_tx_fifo #(
      .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(DB),
      .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data[DB-1:0]),
`ifdef UART_TX_BREAK_EN
      .send_break (send_break),
`endif
      .tx_ready   (rdy_w[g]),
      .txd        (txd_w[g]),
      .tx_busy    (busy_w[g]),
      .fifo_count (cnt_w[g])
    );

    int         starts[$];
    logic [8:0] words[$];
    int         last_start = -1000000;
    int         cnt_prev = 0;

    // Line level of frame bit i (0 = start, then payload, parity, stops).
    function automatic logic fbit(input logic [8:0] w, input int i);
      logic p;
      p = 1'b0;
      for (int b = 0; b < DB; b++) p = p ^ w[b];
      if (i == 0) return 1'b0;
      if (i <= DB) return w[i-1];
      if (i == DB + 1 && PAR != 0) return (PAR == 1) ? ~p : p;
      return 1'b1;
    endfunction

    always @(negedge clk) begin : model
      int   k, cnt, s;
      logic active, exp_txd;
      k = edge_no;
      if (!rst_n) begin
        starts.delete();
        words.delete();
        last_start = -1000000;
        cnt_prev   = 0;
        chk($sformatf("cfg%0d rst txd @%0d", g, k), int'(txd_w[g]), 1);
        chk($sformatf("cfg%0d rst count @%0d", g, k), int'(cnt_w[g]), 0);
        chk($sformatf("cfg%0d rst ready @%0d", g, k), int'(rdy_w[g]), 1);
        chk($sformatf("cfg%0d rst busy @%0d", g, k), int'(busy_w[g]), 0);
      end else begin
        if (r_edge && v_edge && cnt_prev < DEPTH) begin
          s = (k + 1 > last_start + F) ? k + 1 : last_start + F;
          starts.push_back(s);
          words.push_back(d_edge);
          last_start = s;
        end
        while (starts.size() > 0 && starts[0] + F <= k) begin
          void'(starts.pop_front());
          void'(words.pop_front());
        end
        cnt = 0;
        foreach (starts[i]) if (starts[i] > k) cnt++;
        active  = (starts.size() > 0) && (starts[0] <= k);
        exp_txd = active ? fbit(words[0], (k - starts[0]) / CPB) : 1'b1;
        chk($sformatf("cfg%0d txd @%0d", g, k), int'(txd_w[g]), int'(exp_txd));
        chk($sformatf("cfg%0d count @%0d", g, k), int'(cnt_w[g]), cnt);
        chk($sformatf("cfg%0d ready @%0d", g, k), int'(rdy_w[g]), (cnt < DEPTH) ? 1 : 0);
        chk($sformatf("cfg%0d busy @%0d", g, k), int'(busy_w[g]), (active || cnt > 0) ? 1 : 0);
        cnt_prev = cnt;
      end
    end
  end

  task automatic sample_at(input int k);
    while (edge_no < k) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic push_one(input logic [8:0] d, output int n);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #2;
    n = edge_no;
    tx_valid = 1'b0;
  endtask

  initial begin
    int n;
    int acc[6];
    int tries;
    logic r;
    logic [8:0] ew[3];

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset txd", int'(txd_w[0]), 1);
    chk("reset ready", int'(rdy_w[0]), 1);
    chk("reset busy", int'(busy_w[0]), 0);
    chk("reset count", int'(cnt_w[0]), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // 0x55 on 8N1: start falls one edge after accept, 100-cycle frame
    push_one(9'h055, n);
    sample_at(n);
    chk("A count after push", int'(cnt_w[0]), 1);
    chk("A txd idle at accept", int'(txd_w[0]), 1);
    sample_at(n + 1);
    chk("A start bit", int'(txd_w[0]), 0);
    sample_at(n + 10);
    chk("A start last cycle", int'(txd_w[0]), 0);
    sample_at(n + 11);
    chk("A data bit0", int'(txd_w[0]), 1);
    sample_at(n + 21);
    chk("A data bit1", int'(txd_w[0]), 0);
    sample_at(n + 100);
    chk("A stop bit", int'(txd_w[0]), 1);
    chk("A busy in stop", int'(busy_w[0]), 1);
    sample_at(n + 101);
    chk("A busy dropped 8N1", int'(busy_w[0]), 0);
    chk("A busy still 8E1", int'(busy_w[1]), 1);
    sample_at(n + 111);
    chk("A busy dropped 8E1", int'(busy_w[1]), 0);
    @(posedge clk);
    #2;

    // 0x07: even parity bit 1, odd parity bit 0
    push_one(9'h007, n);
    sample_at(n + 81);
    chk("B data bit7", int'(txd_w[1]), 0);
    sample_at(n + 91);
    chk("B even parity", int'(txd_w[1]), 1);
    chk("B odd parity", int'(txd_w[2]), 0);
    chk("B 8N1 stop", int'(txd_w[0]), 1);
    sample_at(n + 115);
    @(posedge clk);
    #2;

    // 0x41, 0x42 back to back: second start immediately after first stop
    tx_valid = 1'b1;
    tx_data  = 9'h041;
    @(posedge clk);
    #2;
    n = edge_no;
    tx_data = 9'h042;
    @(posedge clk);
    #2;
    tx_valid = 1'b0;
    sample_at(n + 100);
    chk("C 7N2 last stop", int'(txd_w[3]), 1);
    sample_at(n + 101);
    chk("C 7N2 second start", int'(txd_w[3]), 0);
    chk("C 8N1 second start", int'(txd_w[0]), 0);
    sample_at(n + 230);
    @(posedge clk);
    #2;

    // Six words held valid until accepted; FIFO fills at four
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1;
      tx_data  = 9'(i + 1);
      tries    = 0;
      do begin
        r = rdy_w[0];
        @(posedge clk);
        #2;
        tries++;
      end while (!r && tries < 500);
      acc[i] = edge_no;
      if (!r) chk("D accept timeout", 0, 1);
    end
    tx_valid = 1'b0;
    chk("D accept 2 offset", acc[1] - acc[0], 1);
    chk("D accept 3 offset", acc[2] - acc[0], 2);
    chk("D accept 4 offset", acc[3] - acc[0], 3);
    chk("D accept 5 offset", acc[4] - acc[0], 4);
    chk("D accept 6 offset", acc[5] - acc[0], 102);
    sample_at(acc[0] + 700);
    @(posedge clk);
    #2;

    // Reset during data bit 3 with two words queued
    ew[0] = 9'h0A5; ew[1] = 9'h03C; ew[2] = 9'h081;
    tx_valid = 1'b1;
    tx_data  = ew[0];
    @(posedge clk);
    #2;
    n = edge_no;
    tx_data = ew[1];
    @(posedge clk);
    #2;
    tx_data = ew[2];
    @(posedge clk);
    #2;
    tx_valid = 1'b0;
    sample_at(n + 45);
    chk("E queued count", int'(cnt_w[0]), 2);
    chk("E data bit3", int'(txd_w[0]), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NCFG; i++) chk($sformatf("E async txd cfg%0d", i), int'(txd_w[i]), 1);
    chk("E async count", int'(cnt_w[0]), 0);
    chk("E async busy", int'(busy_w[0]), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (250) @(posedge clk);
    @(negedge clk);
    chk("E no frame after reset", int'(txd_w[0]), 1);
    chk("E idle after reset", int'(busy_w[0]), 0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
